// File: rtl/handshake_pkg.sv
// ---------------------------------------------------------------------------
// handshake_pkg
// Shared definitions for the B-to-C handshaking link.
//   WORD_W      : beat width on the shared bus
//   BEATS       : beats per frame
//   CNT_W       : width of the completed-frame counter
//   asm_state_e : beat-index state, also used by device B's sender FSM
// ---------------------------------------------------------------------------
package handshake_pkg;

   localparam int WORD_W = 16;
   localparam int BEATS  = 4;
   localparam int CNT_W  = 8;

   // The numeric value of each state is the index of the beat expected next.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ASM1 = 2'd1,
      ASM2 = 2'd2,
      ASM3 = 2'd3
   } asm_state_e;

endpackage : handshake_pkg

// File: rtl/beat_shift_collector.sv
// ---------------------------------------------------------------------------
// beat_shift_collector
// Collects consecutive beats from device B into an assembly register.
// Ports:
//   clk_i         : clock
//   reset_i       : synchronous active-high reset
//   beat_i        : beat data from the shared bus
//   start_i       : high on the cycle carrying beat 0 (readyB)
//   frame_done_o  : high on the cycle the last beat is on beat_i
//   asm_word_o    : full frame, valid while frame_done_o is high
//   framing_err_o : high when start_i arrives in the middle of a frame
// ---------------------------------------------------------------------------
module beat_shift_collector #(
   parameter int WORD_W = 16,
   parameter int BEATS  = 4
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic [WORD_W-1:0]         beat_i,
   input  logic                      start_i,
   output logic                      frame_done_o,
   output logic [WORD_W*BEATS-1:0]   asm_word_o,
   output logic                      framing_err_o
);
   import handshake_pkg::*;

   localparam int FRAME_W = WORD_W * BEATS;

   asm_state_e         state_q, state_d;
   logic [FRAME_W-1:0] asm_q, asm_d;

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
      state_d       = state_q;
      asm_d         = asm_q;
      frame_done_o  = 1'b0;
      framing_err_o = 1'b0;

      if (start_i) begin
         // A start always wins: a partial frame is abandoned and this beat becomes beat 0.
         framing_err_o       = (state_q != IDLE);
         asm_d[WORD_W-1:0]   = beat_i;
         state_d             = ASM1;
      end else if (state_q != IDLE) begin
         asm_d[int'(state_q)*WORD_W +: WORD_W] = beat_i;
         if (state_q == ASM3) begin
            frame_done_o = 1'b1;
            state_d      = IDLE;
         end else begin
            state_d = asm_state_e'(state_q + 2'd1);
         end
      end
   end

   // The last beat bypasses the assembly register so the word is available on the completion edge.
   assign asm_word_o = {beat_i, asm_q[FRAME_W-WORD_W-1:0]};

   always_ff @(posedge clk_i) begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      if (reset_i) begin
         state_q <= IDLE;
         asm_q   <= '0;
      end else begin
         state_q <= state_d;
         asm_q   <= asm_d;
      end
   end

endmodule : beat_shift_collector

// File: rtl/device_c_assembler.sv
// ---------------------------------------------------------------------------
// device_c_assembler
// Receiving end of the B-to-C link: reassembles four-beat frames into one
// word and holds it for a local consumer with a valid/take handshake.
// Ports:
//   clkC        : clock
//   reset       : synchronous active-high reset
//   sharedBusBC : beat data from device B
//   readyB      : high on the cycle carrying beat 0 of a frame
//   takeC       : consumer takes dataOutC while validC is high
//   acceptedC   : one-cycle pulse after a frame is delivered
//   validC      : dataOutC holds an untaken word
//   dataOutC    : reassembled word
//   overrunC    : sticky, a completed frame was dropped
//   framingErrC : sticky, readyB seen mid-frame
//   frameCountC : frames delivered to dataOutC, wraps
// ---------------------------------------------------------------------------
module device_c_assembler #(
   parameter int WORD_W = 16,
   parameter int BEATS  = 4,
   parameter int CNT_W  = 8
) (
   input  logic                      clkC,
   input  logic                      reset,
   input  logic [WORD_W-1:0]         sharedBusBC,
   input  logic                      readyB,
   input  logic                      takeC,
   output logic                      acceptedC,
   output logic                      validC,
   output logic [WORD_W*BEATS-1:0]   dataOutC,
   output logic                      overrunC,
   output logic                      framingErrC,
   output logic [CNT_W-1:0]          frameCountC
);
   import handshake_pkg::*;

   localparam int FRAME_W = WORD_W * BEATS;

   logic               frame_done;
   logic [FRAME_W-1:0] asm_word;
   logic               framing_err;

   logic               accepted_q, accepted_d;
   logic               valid_q,    valid_d;
   logic [FRAME_W-1:0] data_q,     data_d;
   logic               overrun_q,  overrun_d;
   logic               ferr_q,     ferr_d;
   logic [CNT_W-1:0]   count_q,    count_d;

   beat_shift_collector #(
      .WORD_W (WORD_W),
      .BEATS  (BEATS)
   ) u_collector (
      .clk_i         (clkC),
      .reset_i       (reset),
      .beat_i        (sharedBusBC),
      .start_i       (readyB),
      .frame_done_o  (frame_done),
      .asm_word_o    (asm_word),
      .framing_err_o (framing_err)
   );

   always_comb begin
      accepted_d = 1'b0;
      valid_d    = valid_q;
      data_d     = data_q;
      overrun_d  = overrun_q | (frame_done & valid_q & ~takeC);
      ferr_d     = ferr_q | framing_err;
      count_d    = count_q;

      if (frame_done && (!valid_q || takeC)) begin
         // Output register is free, or is being emptied on this same edge.
         data_d     = asm_word;
         valid_d    = 1'b1;
         accepted_d = 1'b1;
         count_d    = count_q + 1'b1;
      end else if (valid_q && takeC) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clkC) begin
      if (reset) begin
         accepted_q <= 1'b0;
         valid_q    <= 1'b0;
         data_q     <= '0;
         overrun_q  <= 1'b0;
         ferr_q     <= 1'b0;
         count_q    <= '0;
      end else begin
         accepted_q <= accepted_d;
         valid_q    <= valid_d;
         data_q     <= data_d;
         overrun_q  <= overrun_d;
         ferr_q     <= ferr_d;
         count_q    <= count_d;
      end
   end

   assign acceptedC   = accepted_q;
   assign validC      = valid_q;
   assign dataOutC    = data_q;
   assign overrunC    = overrun_q;
   assign framingErrC = ferr_q;
   assign frameCountC = count_q;

endmodule : device_c_assembler

// File: tb/tb_device_c_assembler.sv
// ---------------------------------------------------------------------------
// tb_device_c_assembler
// Directed stimulus with hand-computed literal expectations, plus a
// history-based reference model compared against the DUT every cycle.
// ---------------------------------------------------------------------------
module tb_device_c_assembler;

   logic        clkC = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] sharedBusBC = '0;
   logic        readyB = 1'b0;
   logic        takeC = 1'b0;
   logic        acceptedC;
   logic        validC;
   logic [63:0] dataOutC;
   logic        overrunC;
   logic        framingErrC;
   logic [7:0]  frameCountC;

   int checks   = 0;
   int failures = 0;

   device_c_assembler dut (
      .clkC        (clkC),
      .reset       (reset),
      .sharedBusBC (sharedBusBC),
      .readyB      (readyB),
      .takeC       (takeC),
      .acceptedC   (acceptedC),
      .validC      (validC),
      .dataOutC    (dataOutC),
      .overrunC    (overrunC),
      .framingErrC (framingErrC),
      .frameCountC (frameCountC)
   );

   always #5 clkC = ~clkC;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // A frame completes on an edge when readyB was seen exactly three edges
   // earlier and not since (including now). A framing error is readyB while
   // any readyB was seen in the previous three edges.
   logic        h_ready [3];   // [0] = previous edge, [2] = three edges ago
   logic [15:0] h_beat  [3];
   logic        m_acc, m_valid, m_ovr, m_ferr;
   logic [63:0] m_data;
   logic [7:0]  m_cnt;
   bit          model_ok = 0;

   always @(posedge clkC) begin
      logic        complete;
      logic [63:0] word;
      if (reset) begin
         for (int i = 0; i < 3; i++) begin
            h_ready[i] = 1'b0;
            h_beat[i]  = '0;
         end
         m_acc = 0; m_valid = 0; m_ovr = 0; m_ferr = 0; m_data = '0; m_cnt = '0;
         model_ok = 1;
      end else if (model_ok) begin
         complete = h_ready[2] && !h_ready[1] && !h_ready[0] && !readyB;
         word     = {sharedBusBC, h_beat[0], h_beat[1], h_beat[2]};
         if (readyB && (h_ready[0] || h_ready[1] || h_ready[2])) m_ferr = 1;
         m_acc = 0;
         if (complete) begin
            if (m_valid && !takeC) m_ovr = 1;
            else begin
               m_data  = word;
               m_valid = 1;
               m_acc   = 1;
               m_cnt   = m_cnt + 8'd1;
            end
         end else if (takeC) begin
            m_valid = 0;
         end
         h_ready[2] = h_ready[1]; h_ready[1] = h_ready[0]; h_ready[0] = readyB;
         h_beat[2]  = h_beat[1];  h_beat[1]  = h_beat[0];  h_beat[0]  = sharedBusBC;
      end
   end

   // Compare process: sampled on the falling edge, away from the active edge.
   always @(negedge clkC) begin
      if (model_ok) begin
         check("acceptedC",   {63'd0, acceptedC},   {63'd0, m_acc});
         check("validC",      {63'd0, validC},      {63'd0, m_valid});
         check("dataOutC",    dataOutC,             m_data);
         check("overrunC",    {63'd0, overrunC},    {63'd0, m_ovr});
         check("framingErrC", {63'd0, framingErrC}, {63'd0, m_ferr});
         check("frameCountC", {56'd0, frameCountC}, {56'd0, m_cnt});
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc(input logic r, input logic [15:0] b, input logic t);
      readyB      = r;
      sharedBusBC = b;
      takeC       = t;
      @(posedge clkC);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc(1'b0, 16'h0, 1'b0);
      cyc(1'b0, 16'h0, 1'b0);
      reset = 1'b0;
   endtask

   task automatic frame(input logic [15:0] b0, b1, b2, b3, input logic t);
      cyc(1'b1, b0, t);
      cyc(1'b0, b1, t);
      cyc(1'b0, b2, t);
      cyc(1'b0, b3, t);
   endtask

   initial begin
      // Reset state
      do_reset();
      check("rst_valid", {63'd0, validC}, 64'd0);
      check("rst_acc",   {63'd0, acceptedC}, 64'd0);
      check("rst_data",  dataOutC, 64'd0);
      check("rst_cnt",   {56'd0, frameCountC}, 64'd0);

      // Basic frame, four cycles of latency
      frame(16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b0);
      check("t1_data",  dataOutC, 64'h4444_3333_2222_1111);
      check("t1_valid", {63'd0, validC}, 64'd1);
      check("t1_acc",   {63'd0, acceptedC}, 64'd1);
      check("t1_cnt",   {56'd0, frameCountC}, 64'd1);
      cyc(1'b0, 16'h0, 1'b0);
      check("t1_acc_one_cycle", {63'd0, acceptedC}, 64'd0);
      check("t1_hold",  dataOutC, 64'h4444_3333_2222_1111);

      // Back-to-back frames with the consumer always taking
      do_reset();
      frame(16'h5550, 16'h5551, 16'h5552, 16'h5553, 1'b1);
      check("t2_cnt1", {56'd0, frameCountC}, 64'd1);
      frame(16'h6660, 16'h6661, 16'h6662, 16'h6663, 1'b1);
      check("t2_data",  dataOutC, 64'h6663_6662_6661_6660);
      check("t2_valid", {63'd0, validC}, 64'd1);
      check("t2_ovr",   {63'd0, overrunC}, 64'd0);
      check("t2_cnt2",  {56'd0, frameCountC}, 64'd2);
      cyc(1'b0, 16'h0, 1'b1);
      check("t2_taken", {63'd0, validC}, 64'd0);

      // Overrun: second frame completes while the first is still held
      do_reset();
      frame(16'h0001, 16'h0002, 16'h0003, 16'h0004, 1'b0);
      frame(16'hAAAA, 16'hAAAB, 16'hAAAC, 16'hAAAD, 1'b0);
      check("t3_data", dataOutC, 64'h0004_0003_0002_0001);
      check("t3_ovr",  {63'd0, overrunC}, 64'd1);
      check("t3_acc",  {63'd0, acceptedC}, 64'd0);
      check("t3_cnt",  {56'd0, frameCountC}, 64'd1);
      cyc(1'b0, 16'h0, 1'b1);
      check("t3_taken", {63'd0, validC}, 64'd0);
      cyc(1'b0, 16'h0, 1'b1);
      check("t3_sticky", {63'd0, overrunC}, 64'd1);

      // Framing error: readyB reasserted on the ASM2 cycle
      do_reset();
      cyc(1'b1, 16'h1001, 1'b0);
      cyc(1'b0, 16'h1002, 1'b0);
      cyc(1'b1, 16'hBEEF, 1'b0);
      check("t4_ferr", {63'd0, framingErrC}, 64'd1);
      cyc(1'b0, 16'hC001, 1'b0);
      cyc(1'b0, 16'hC002, 1'b0);
      cyc(1'b0, 16'hC003, 1'b0);
      check("t4_data", dataOutC, 64'hC003_C002_C001_BEEF);
      check("t4_cnt",  {56'd0, frameCountC}, 64'd1);

      // Reset during ASM2, then a clean frame
      do_reset();
      cyc(1'b1, 16'h9990, 1'b0);
      cyc(1'b0, 16'h9991, 1'b0);
      reset = 1'b1;
      cyc(1'b0, 16'h9992, 1'b0);
      reset = 1'b0;
      check("t5_valid", {63'd0, validC}, 64'd0);
      check("t5_data",  dataOutC, 64'd0);
      check("t5_ferr",  {63'd0, framingErrC}, 64'd0);
      cyc(1'b0, 16'h9993, 1'b0);
      cyc(1'b0, 16'h0, 1'b0);
      check("t5_no_acc", {63'd0, acceptedC}, 64'd0);
      check("t5_cnt0",   {56'd0, frameCountC}, 64'd0);
      frame(16'h7770, 16'h7771, 16'h7772, 16'h7773, 1'b0);
      check("t5_data2", dataOutC, 64'h7773_7772_7771_7770);
      check("t5_cnt1",  {56'd0, frameCountC}, 64'd1);

      // 256 taken frames: counter wraps to zero, no flags
      do_reset();
      for (int i = 0; i < 256; i++) begin
         frame(i[15:0], 16'h0100, 16'h0200, 16'h0300, 1'b1);
         if (i == 254) check("t6_cnt255", {56'd0, frameCountC}, 64'hFF);
      end
      check("t6_wrap", {56'd0, frameCountC}, 64'd0);
      check("t6_ovr",  {63'd0, overrunC}, 64'd0);
      check("t6_ferr", {63'd0, framingErrC}, 64'd0);
      check("t6_data", dataOutC, 64'h0300_0200_0100_00FF);
      cyc(1'b0, 16'h0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_device_c_assembler
